// File: rtl/stream_arbiter.sv
// Round-robin arbiter merging N producer streams, each buffered by its own
// small FIFO, into one registered output stream tagged with the source index.
module stream_arbiter #(
    parameter int WDTH      = 32,
    parameter int MWDTH     = 1,
    parameter int N_LOG     = 2,
    parameter int LOG_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [(2**N_LOG)*WDTH-1:0]  in_data,
    input  logic [(2**N_LOG)-1:0]       in_nd,
    input  logic [(2**N_LOG)*MWDTH-1:0] in_m,
    output logic [(2**N_LOG)-1:0]       in_full,
    output logic [WDTH-1:0]             out_data,
    output logic                        out_nd,
    output logic [MWDTH-1:0]            out_m,
    output logic [N_LOG-1:0]            out_src,
    output logic [(2**N_LOG)-1:0]       ovf,
    output logic                        error
);

    localparam int N     = 2**N_LOG;
    localparam int DEPTH = 2**LOG_DEPTH;
    localparam int EW    = WDTH + MWDTH;

    logic [EW-1:0]      mem [N][DEPTH];
    logic [LOG_DEPTH:0] wr_ptr [N];
    logic [LOG_DEPTH:0] rd_ptr [N];
    logic [N-1:0]       empty;
    logic [N-1:0]       full;
    logic [N-1:0]       push;
    logic [N-1:0]       pop;
    logic [N_LOG-1:0]   rr_ptr;
    logic [N_LOG-1:0]   scan_idx;
    logic [N_LOG-1:0]   grant_idx;
    logic               grant_vld;
    logic [EW-1:0]      head_word;

    // Full when the low address bits match but the wrap bits differ.
    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < N; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][LOG_DEPTH] != rd_ptr[i][LOG_DEPTH]) &&
                       (wr_ptr[i][LOG_DEPTH-1:0] == rd_ptr[i][LOG_DEPTH-1:0]);
        end
    end

    assign in_full = full;

    // Scan downward so the closest non-empty index after rr_ptr wins last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = rr_ptr + N_LOG'(k);
            if (!empty[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        pop  = '0;
        push = '0;
        for (int i = 0; i < N; i++) begin
            pop[i]  = grant_vld && (grant_idx == N_LOG'(i));
            push[i] = in_nd[i] && (!full[i] || pop[i]);
        end
    end

    assign head_word = mem[grant_idx][rd_ptr[grant_idx][LOG_DEPTH-1:0]];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][LOG_DEPTH-1:0]] <= {in_m[i*MWDTH +: MWDTH],
                                                     in_data[i*WDTH +: WDTH]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + (LOG_DEPTH+1)'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + (LOG_DEPTH+1)'(1);
                end
                if (in_nd[i] && full[i] && !pop[i]) begin
                    ovf[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            out_nd   <= 1'b0;
            out_data <= '0;
            out_m    <= '0;
            out_src  <= '0;
        end else begin
            out_nd <= grant_vld;
            if (grant_vld) begin
                rr_ptr   <= grant_idx + N_LOG'(1);
                out_data <= head_word[WDTH-1:0];
                out_m    <= head_word[EW-1:WDTH];
                out_src  <= grant_idx;
            end
        end
    end

    assign error = |ovf;

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter with 4 requesters and depth-4 FIFOs.
module tb_stream_arbiter;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_nd;
    logic [3:0]   in_m;
    logic [3:0]   in_full;
    logic [31:0]  out_data;
    logic         out_nd;
    logic [0:0]   out_m;
    logic [1:0]   out_src;
    logic [3:0]   ovf;
    logic         error;

    int total;
    int bad;

    stream_arbiter #(.WDTH(32), .MWDTH(1), .N_LOG(2), .LOG_DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_nd    (in_nd),
        .in_m     (in_m),
        .in_full  (in_full),
        .out_data (out_data),
        .out_nd   (out_nd),
        .out_m    (out_m),
        .out_src  (out_src),
        .ovf      (ovf),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_nd   = '0;
        in_data = '0;
        in_m    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive(input int i, input logic [31:0] d, input logic m);
        in_nd[i]          = 1'b1;
        in_data[i*32 +: 32] = d;
        in_m[i]           = m;
    endtask

    task automatic test_reset();
        logic [43:0] got;
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_nd   = 4'($urandom_range(0, 15));
            in_m    = 4'($urandom_range(0, 15));
            tick();
            got = {out_data, out_nd, out_m, out_src, ovf, error, in_full};
            total++;
            if (got !== 44'h0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got %h want 0", c, got);
            end
        end
        idle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (out_nd !== 1'b0) begin
                bad++;
                $display("FAIL idle_out_nd cycle %0d: got %b want 0", c, out_nd);
            end
        end
    endtask

    task automatic test_single_stream();
        logic [31:0] exp_d [3];
        logic        exp_m [3];
        exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
        exp_m[0] = 1'b1;   exp_m[1] = 1'b0;   exp_m[2] = 1'b1;
        idle();
        drive(1, exp_d[0], exp_m[0]);
        tick();
        total++;
        if (out_nd !== 1'b0) begin
            bad++;
            $display("FAIL single_latency: out_nd got %b want 0", out_nd);
        end
        for (int j = 0; j < 3; j++) begin
            idle();
            if (j < 2) drive(1, exp_d[j+1], exp_m[j+1]);
            tick();
            total++;
            if ({out_nd, out_src, out_data, out_m} !== {1'b1, 2'd1, exp_d[j], exp_m[j]}) begin
                bad++;
                $display("FAIL single_word%0d: nd=%b src=%0d data=%h m=%b want nd=1 src=1 data=%h m=%b",
                         j, out_nd, out_src, out_data, out_m, exp_d[j], exp_m[j]);
            end
        end
        tick();
        total++;
        if (out_nd !== 1'b0) begin
            bad++;
            $display("FAIL single_tail: out_nd got %b want 0", out_nd);
        end
    endtask

    task automatic test_all_same_cycle();
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 32'hA0 + 32'(i), 1'(i));
        tick();
        idle();
        for (int j = 0; j < 4; j++) begin
            tick();
            total++;
            if ({out_nd, out_src, out_data} !== {1'b1, 2'(j), 32'hA0 + 32'(j)}) begin
                bad++;
                $display("FAIL all4_word%0d: nd=%b src=%0d data=%h want nd=1 src=%0d data=%h",
                         j, out_nd, out_src, out_data, j, 32'hA0 + 32'(j));
            end
        end
        tick();
        total++;
        if (out_nd !== 1'b0) begin
            bad++;
            $display("FAIL all4_tail: out_nd got %b want 0", out_nd);
        end
    endtask

    task automatic test_fair_two();
        logic [1:0]  exp_s;
        logic [31:0] exp_d;
        do_reset();
        drive(0, 32'h0000_00FF, 1'b0);
        tick();
        idle();
        tick();
        tick();
        // rr pointer now at 1; FIFOs 0 and 3 fill over 4 cycles
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c < 4) begin
                drive(0, 32'h0400 + 32'(c), 1'b0);
                drive(3, 32'h3400 + 32'(c), 1'b1);
            end
            tick();
            if (c >= 1 && c <= 8) begin
                exp_s = (c % 2 == 1) ? 2'd3 : 2'd0;
                exp_d = ((exp_s == 2'd3) ? 32'h3400 : 32'h0400) + 32'((c - 1) / 2);
                total++;
                if ({out_nd, out_src, out_data} !== {1'b1, exp_s, exp_d}) begin
                    bad++;
                    $display("FAIL fair_c%0d: nd=%b src=%0d data=%h want nd=1 src=%0d data=%h",
                             c, out_nd, out_src, out_data, exp_s, exp_d);
                end
            end
        end
        total++;
        if (out_nd !== 1'b0) begin
            bad++;
            $display("FAIL fair_tail: out_nd got %b want 0", out_nd);
        end
    endtask

    task automatic test_overflow();
        int last_seq [4];
        int src_cnt  [4];
        int n_out;
        int first_e;
        int last_e;
        int exp_cnt  [4];
        exp_cnt[0] = 7; exp_cnt[1] = 7; exp_cnt[2] = 7; exp_cnt[3] = 6;
        for (int i = 0; i < 4; i++) begin
            last_seq[i] = 0;
            src_cnt[i]  = 0;
        end
        n_out = 0; first_e = -1; last_e = -1;
        do_reset();
        for (int c = 1; c <= 32; c++) begin
            idle();
            if (c <= 12) begin
                for (int i = 0; i < 4; i++) drive(i, 32'((i << 8) | c), 1'(c));
            end
            tick();
            if (c == 4) begin
                total++;
                if (in_full !== 4'h8) begin
                    bad++;
                    $display("FAIL ovf_in_full_e4: got %h want 8", in_full);
                end
            end
            if (c == 5) begin
                total++;
                if ({in_full, ovf} !== {4'hF, 4'h0}) begin
                    bad++;
                    $display("FAIL ovf_e5: in_full=%h ovf=%h want F 0", in_full, ovf);
                end
            end
            if (c == 6) begin
                total++;
                if ({ovf, error} !== {4'hE, 1'b1}) begin
                    bad++;
                    $display("FAIL ovf_e6: ovf=%h error=%b want E 1", ovf, error);
                end
            end
            if (out_nd === 1'b1) begin
                n_out++;
                if (first_e < 0) first_e = c;
                last_e = c;
                src_cnt[out_src]++;
                total++;
                if (out_data[15:8] !== 8'(out_src) || int'(out_data[7:0]) <= last_seq[out_src] ||
                    out_m !== 1'(out_data[0])) begin
                    bad++;
                    $display("FAIL ovf_order e%0d: src=%0d data=%h m=%b prev_seq=%0d",
                             c, out_src, out_data, out_m, last_seq[out_src]);
                end
                last_seq[out_src] = int'(out_data[7:0]);
            end
        end
        total++;
        if (n_out != 27 || first_e != 2 || last_e != 28) begin
            bad++;
            $display("FAIL ovf_stream: words=%0d first=%0d last=%0d want 27 2 28", n_out, first_e, last_e);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (src_cnt[i] != exp_cnt[i]) begin
                bad++;
                $display("FAIL ovf_src%0d_count: got %0d want %0d", i, src_cnt[i], exp_cnt[i]);
            end
        end
        total++;
        if ({ovf, error} !== {4'hF, 1'b1}) begin
            bad++;
            $display("FAIL ovf_sticky: ovf=%h error=%b want F 1", ovf, error);
        end
    endtask

    task automatic test_mid_reset();
        logic [43:0] got;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 4; i++) drive(i, 32'h5500 + 32'(i * 16 + c), 1'b0);
            tick();
        end
        idle();
        total++;
        if (out_nd !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre: out_nd got %b want 1", out_nd);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {out_data, out_nd, out_m, out_src, ovf, error, in_full};
        total++;
        if (got !== 44'h0) begin
            bad++;
            $display("FAIL midrst_outputs: got %h want 0", got);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (out_nd !== 1'b0) begin
                bad++;
                $display("FAIL midrst_stale cycle %0d: out_nd got %b want 0", c, out_nd);
            end
        end
        drive(1, 32'hB1, 1'b0);
        drive(2, 32'hB2, 1'b1);
        tick();
        idle();
        tick();
        total++;
        if ({out_nd, out_src, out_data} !== {1'b1, 2'd1, 32'hB1}) begin
            bad++;
            $display("FAIL midrst_first: nd=%b src=%0d data=%h want 1 1 b1", out_nd, out_src, out_data);
        end
        tick();
        total++;
        if ({out_nd, out_src, out_data, out_m} !== {1'b1, 2'd2, 32'hB2, 1'b1}) begin
            bad++;
            $display("FAIL midrst_second: nd=%b src=%0d data=%h m=%b want 1 2 b2 1",
                     out_nd, out_src, out_data, out_m);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        #3;
        test_reset();
        test_single_stream();
        test_all_same_cycle();
        test_fair_two();
        test_overflow();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
